// File: rtl/keypad_entry_sequencer.sv
// keypad_entry_sequencer: shifts up to three BCD key digits as M:ST, validates on start, pulses the timer load, then locks out the keypad until the timer finishes
module keypad_entry_sequencer #(
  parameter int MAX_SEC_TENS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_busy,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] minutes,
  output logic [1:0] count,
  output logic       load_timer,
  output logic       entry_error
);
  typedef enum logic [2:0] {IDLE, ENTRY, FULL, WAIT_BUSY, RUN} state_t;
  state_t state, state_n;
  logic load_q;
  logic [3:0] sec_ones_n, sec_tens_n, minutes_n;
  logic [1:0] count_n;
  logic load_timer_n, entry_error_n, key_ok;
  assign key_ok = load & ~load_q & (digit <= 4'd9);
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      load_q      <= 1'b1;
      sec_ones    <= '0;
      sec_tens    <= '0;
      minutes     <= '0;
      count       <= '0;
      load_timer  <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_n;
      load_q      <= load;
      sec_ones    <= sec_ones_n;
      sec_tens    <= sec_tens_n;
      minutes     <= minutes_n;
      count       <= count_n;
      load_timer  <= load_timer_n;
      entry_error <= entry_error_n;
    end
  end
  always_comb begin
    state_n       = state;
    sec_ones_n    = sec_ones;
    sec_tens_n    = sec_tens;
    minutes_n     = minutes;
    count_n       = count;
    load_timer_n  = 1'b0;
    entry_error_n = entry_error;
    case (state)
      IDLE, ENTRY, FULL: begin
        if (cancel) begin
          state_n       = IDLE;
          sec_ones_n    = '0;
          sec_tens_n    = '0;
          minutes_n     = '0;
          count_n       = '0;
          entry_error_n = 1'b0;
        end else if (start && state != IDLE) begin
          if (32'(sec_tens) > MAX_SEC_TENS) begin
            entry_error_n = 1'b1;
          end else begin
            load_timer_n  = 1'b1;
            entry_error_n = 1'b0;
            state_n       = WAIT_BUSY;
          end
        end else if (key_ok && state != FULL) begin
          minutes_n     = sec_tens;
          sec_tens_n    = sec_ones;
          sec_ones_n    = digit;
          count_n       = count + 2'd1;
          entry_error_n = 1'b0;
          state_n       = (count == 2'd2) ? FULL : ENTRY;
        end
      end
      WAIT_BUSY: state_n = timer_busy ? RUN : WAIT_BUSY;
      RUN: begin
        if (!timer_busy) begin
          state_n       = IDLE;
          sec_ones_n    = '0;
          sec_tens_n    = '0;
          minutes_n     = '0;
          count_n       = '0;
          entry_error_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
